// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide unit for the E stage. It owns the architectural
// HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
// The result of a mult/div is computed in the start cycle and held in a
// pending register. It is committed to HI/LO when the busy countdown expires,
// so the visible latency matches a real iterative unit.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous active-low reset
//   start  in   1  E-stage instruction is a mul/div/mthi/mtlo (qualified by md_op)
//   md_op  in   3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   A      in  32  rs operand (forwarded)
//   B      in  32  rt operand (forwarded)
//   busy   out  1  mul/div starting this cycle or in progress (to hazard unit)
//   HI     out 32  architectural HI register
//   LO     out 32  architectural LO register
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    md_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_valid_r;

    logic [63:0]      prod_s;
    logic [31:0]      a_mag_s;
    logic [31:0]      b_mag_s;
    logic [31:0]      divisor_s;
    logic [31:0]      uquot_s;
    logic [31:0]      urem_s;
    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;
    logic             res_valid_s;
    logic             is_md_s;

    assign is_md_s = (md_op <= 3'd3);

    // Combinational result datapath: product, quotient and remainder for md_op.
    always_comb begin
        prod_s      = 64'd0;
        a_mag_s     = A;
        b_mag_s     = B;
        divisor_s   = 32'd1;
        uquot_s     = 32'd0;
        urem_s      = 32'd0;
        res_hi_s    = 32'd0;
        res_lo_s    = 32'd0;
        res_valid_s = 1'b0;

        case (md_op)
            3'd0: begin
                // Sign-extended 64x64 multiply; the low 64 bits are the signed product.
                prod_s      = {{32{A[31]}}, A} * {{32{B[31]}}, B};
                res_hi_s    = prod_s[63:32];
                res_lo_s    = prod_s[31:0];
                res_valid_s = 1'b1;
            end
            3'd1: begin
                prod_s      = {32'd0, A} * {32'd0, B};
                res_hi_s    = prod_s[63:32];
                res_lo_s    = prod_s[31:0];
                res_valid_s = 1'b1;
            end
            3'd2: begin
                // Divide magnitudes, then fix signs. The quotient is negative when
                // the operand signs differ, and the remainder follows the dividend.
                // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
                if (A[31]) begin
                    a_mag_s = 32'd0 - A;
                end else begin
                    a_mag_s = A;
                end
                if (B[31]) begin
                    b_mag_s = 32'd0 - B;
                end else begin
                    b_mag_s = B;
                end
                // Keep the divider defined for B==0; that result is never committed.
                if (B == 32'd0) begin
                    divisor_s = 32'd1;
                end else begin
                    divisor_s = b_mag_s;
                end
                uquot_s = a_mag_s / divisor_s;
                urem_s  = a_mag_s % divisor_s;
                if (A[31] ^ B[31]) begin
                    res_lo_s = 32'd0 - uquot_s;
                end else begin
                    res_lo_s = uquot_s;
                end
                if (A[31]) begin
                    res_hi_s = 32'd0 - urem_s;
                end else begin
                    res_hi_s = urem_s;
                end
                res_valid_s = (B != 32'd0);
            end
            3'd3: begin
                if (B == 32'd0) begin
                    divisor_s = 32'd1;
                end else begin
                    divisor_s = B;
                end
                uquot_s     = A / divisor_s;
                urem_s      = A % divisor_s;
                res_lo_s    = uquot_s;
                res_hi_s    = urem_s;
                res_valid_s = (B != 32'd0);
            end
            default: begin
                res_valid_s = 1'b0;
            end
        endcase
    end

    // Control FSM, countdown, pending-result capture and HI/LO commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            hi_r         <= 32'd0;
            lo_r         <= 32'd0;
            pend_hi_r    <= 32'd0;
            pend_lo_r    <= 32'd0;
            pend_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            3'd0, 3'd1: begin
                                pend_hi_r    <= res_hi_s;
                                pend_lo_r    <= res_lo_s;
                                pend_valid_r <= res_valid_s;
                                cnt_r        <= CNT_W'(MULT_CYCLES);
                                state_r      <= ST_BUSY;
                            end
                            3'd2, 3'd3: begin
                                pend_hi_r    <= res_hi_s;
                                pend_lo_r    <= res_lo_s;
                                pend_valid_r <= res_valid_s;
                                cnt_r        <= CNT_W'(DIV_CYCLES);
                                state_r      <= ST_BUSY;
                            end
                            3'd4: begin
                                hi_r <= A;
                            end
                            3'd5: begin
                                lo_r <= A;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Starts arriving while busy are ignored; only the countdown runs.
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        // A divide by zero leaves HI/LO untouched.
                        if (pend_valid_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Busy must be combinational so that a same-cycle mfhi/mflo in D stalls.
    // It is forced low while reset is held.
    assign busy = reset & ((start & is_md_s & (state_r == ST_IDLE)) | (state_r == ST_BUSY));

    assign HI = hi_r;
    assign LO = lo_r;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    // Reference architectural state.
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: what HI/LO become after the operation completes.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] oh, input logic [31:0] ol,
                                   output logic [31:0] nh, output logic [31:0] nl);
        longint sa;
        longint sb;
        longint sp;
        longint sq;
        longint sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        nh = oh;
        nl = ol;
        case (op)
            3'd0: begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; end
            3'd1: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; end
            3'd2: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; nl = sq[31:0]; nh = sr[31:0]; end
            3'd3: if (b != 32'd0) begin up = ua / ub; nl = up[31:0]; up = ua % ub; nh = up[31:0]; end
            3'd4: nh = a;
            3'd5: nl = a;
            default: begin nh = oh; nl = ol; end
        endcase
    endfunction

    function automatic int op_cycles(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    // Issue one operation and check busy and HI/LO in every cycle until it completes.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] nh;
        logic [31:0] nl;
        logic        exp_busy;
        int          n;
        ref_op(op, a, b, hi_m, lo_m, nh, nl);
        n = op_cycles(op);
        exp_busy = (op <= 3'd3);
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b;
        #1;
        checks++;
        if (busy !== exp_busy) begin
            errors++; $display("FAIL %s busy@c0 got %0b exp %0b", tag, busy, exp_busy);
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start = 1'b0; md_op = 3'd7; A = $urandom; B = $urandom;
            #1;
            checks++;
            if (busy !== 1'b1 || HI !== hi_m || LO !== lo_m) begin
                errors++;
                $display("FAIL %s c%0d busy=%0b HI=%h LO=%h exp busy=1 HI=%h LO=%h", tag, c, busy, HI, LO, hi_m, lo_m);
            end
        end
        @(negedge clk);
        start = 1'b0; md_op = 3'd7;
        #1;
        hi_m = nh; lo_m = nl;
        checks++;
        if (busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
            errors++;
            $display("FAIL %s done busy=%0b HI=%h LO=%h exp busy=0 HI=%h LO=%h", tag, busy, HI, LO, hi_m, lo_m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; md_op = 3'd0; A = 32'hFFFF_FFFF; B = 32'd2;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL reset busy=%0b HI=%h LO=%h exp 0 0 0", busy, HI, LO);
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, "mult");
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL mult_const HI=%h LO=%h exp ffffffff fffffffe", HI, LO);
        end
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu");
        checks++;
        if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL multu_const HI=%h LO=%h exp 00000001 fffffffe", HI, LO);
        end
    endtask

    task automatic test_div();
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div");
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_const HI=%h LO=%h exp ffffffff fffffffd", HI, LO);
        end
        run_op(3'd3, 32'd7, 32'd2, "divu");
        checks++;
        if (HI !== 32'd1 || LO !== 32'd3) begin
            errors++; $display("FAIL divu_const HI=%h LO=%h exp 1 3", HI, LO);
        end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        checks++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            errors++; $display("FAIL div_ovf_const HI=%h LO=%h exp 0 80000000", HI, LO);
        end
    endtask

    task automatic test_div_by_zero();
        run_op(3'd4, 32'h1234, 32'd0, "mthi");
        run_op(3'd5, 32'h5678, 32'd0, "mtlo");
        run_op(3'd2, 32'd99, 32'd0, "div0");
        run_op(3'd3, 32'd99, 32'd0, "divu0");
        checks++;
        if (HI !== 32'h1234 || LO !== 32'h5678) begin
            errors++; $display("FAIL div0_const HI=%h LO=%h exp 1234 5678", HI, LO);
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] nh;
        logic [31:0] nl;
        ref_op(3'd2, 32'd100, 32'd7, hi_m, lo_m, nh, nl);
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            // Cycle 3 carries a second mult start that must be ignored.
            start = (c == 3); md_op = (c == 3) ? 3'd0 : 3'd7; A = 32'd3; B = 32'd5;
            #1;
            checks++;
            if (busy !== 1'b1 || HI !== hi_m || LO !== lo_m) begin
                errors++; $display("FAIL busy_start c%0d busy=%0b HI=%h LO=%h", c, busy, HI, LO);
            end
        end
        @(negedge clk);
        start = 1'b0; md_op = 3'd7;
        #1;
        hi_m = nh; lo_m = nl;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd14) begin
            errors++; $display("FAIL busy_start_commit busy=%0b HI=%h LO=%h exp 0 2 14", busy, HI, LO);
        end
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
            errors++; $display("FAIL busy_start_late busy=%0b HI=%h LO=%h exp 0 %h %h", busy, HI, LO, hi_m, lo_m);
        end
    endtask

    task automatic test_reset_mid_op();
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, "pre_mthi");
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; A = 32'd1000; B = 32'd1000;
        repeat (3) @(negedge clk);
        start = 1'b0; md_op = 3'd7;
        reset = 1'b0;
        #1;
        hi_m = 32'd0; lo_m = 32'd0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL reset_mid busy=%0b HI=%h LO=%h exp 0 0 0", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
                errors++; $display("FAIL reset_late c%0d busy=%0b HI=%h LO=%h exp 0 0 0", c, busy, HI, LO);
            end
        end
        run_op(3'd1, 32'd6, 32'd7, "post_reset_multu");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = 32'($urandom);
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd7; A = 32'd0; B = 32'd0;
        hi_m = 32'd0; lo_m = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
